mux_nx1_arb: RTL and testbench
==============================

# mux_nx1_arb

Parametrised N-input, registered operand selector with per-channel valid/ready handshaking. It is the successor to the 2:1 operand-B mux in the datapath. It adds a configurable channel count, a one-entry output register, and two selection modes: fixed select and round-robin arbitration among valid channels. It sits between the operand sources (external input, data memory, immediate, forwarding paths) and the ALU operand register.

## Interface
- `DATA_WIDTH`, 16, width of every data channel and of the output.
- `CHANNELS`, 4, number of input channels; legal range 2..16.
- `SEL_WIDTH`, `$clog2(CHANNELS)`, width of the select and channel-index fields; derived, do not override.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  `CHANNELS*DATA_WIDTH`  packed channel data; channel k occupies bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `in_valid`  in  `CHANNELS`  per-channel data-valid.
- `in_ready`  out  `CHANNELS`  per-channel accept; combinational, at most one bit set (one-hot or zero).
- `mode`  in  1  0 = fixed select, 1 = round-robin.
- `select_nx1`  in  `SEL_WIDTH`  channel index used in fixed mode; ignored in round-robin.
- `out_data`  out  `DATA_WIDTH`  registered selected data.
- `out_valid`  out  1  output register holds valid data.
- `out_ready`  in  1  downstream accept.
- `out_channel`  out  `SEL_WIDTH`  index of the channel whose data is in the output register.

## Operation
- Output register has two states. EMPTY is `out_valid`=0; FULL is `out_valid`=1.
- Free condition: `can_load = !out_valid || out_ready`.
- Grant, fixed mode (`mode`=0):
  - Candidate is `select_nx1`.
  - Grant is asserted iff `select_nx1` < `CHANNELS` and `in_valid[select_nx1]`=1.
  - A select value ≥ `CHANNELS` grants nothing. No wrap, no X propagation.
- Grant, round-robin mode (`mode`=1):
  - Search for the first channel with `in_valid`=1, starting at `rr_ptr+1` and wrapping modulo `CHANNELS`.
  - `rr_ptr` is the last granted channel. The channel at `rr_ptr` is searched last.
- `in_ready[g]` = `can_load` && grant; every other bit is 0. The granted channel is the only one that may transfer.
- Input transfer occurs when `in_valid[g]` && `in_ready[g]`. On the next edge:
  - `out_data` ← channel g data.
  - `out_channel` ← g.
  - `out_valid` ← 1.
  - `rr_ptr` ← g (in both modes, so switching modes resumes fairly).
- Drain: when `out_valid` && `out_ready` and no input transfer, `out_valid` ← 0.
  - `out_data` and `out_channel` hold their last values.
- Simultaneous drain and load: the register reloads with no bubble and `out_valid` stays 1.
- FULL with `out_ready`=0: all `in_ready`=0. `out_data`, `out_channel` and `out_valid` are held stable.
- `mode` and `select_nx1` may change on any cycle. They affect only the combinational grant of that cycle and never disturb a held output.
- Reset (asynchronous assert, synchronous deassert by the environment), applied at any time including mid-transfer:
  - `out_valid`=0, `out_data`=0, `out_channel`=0.
  - `rr_ptr`=`CHANNELS-1`, so channel 0 has first priority after reset.
  - Any pending transfer is dropped.

## Timing
- Latency is 1 cycle: data accepted at edge N is visible on `out_data` after edge N.
- Throughput is one word per cycle when `out_ready` is held 1.
- `in_ready` depends combinationally on `out_ready`, `out_valid`, `in_valid`, `mode` and `select_nx1`. There is no combinational path from `in_data` to any output.
- While `rst_n`=0, all `in_ready` are 0.

## Test plan
- **Reset:**
  - Stimulus: drive `rst_n`=0 mid-cycle while FULL with `out_data`=16'h0049.
  - Required: immediately `out_valid`=0, `out_data`=0, `out_channel`=0, `in_ready`=0. The first round-robin grant after release goes to channel 0.
- **Fixed select:**
  - Stimulus: `mode`=0, `select_nx1`=1, ch1=16'h0064 valid, `out_ready`=1.
  - Required: `out_data`=16'h0064 and `out_channel`=1 one cycle later. Then switch to `select_nx1`=0 with ch0=16'hFF49 and expect `out_data`=16'hFF49 the next cycle.
- **Out-of-range select:**
  - Stimulus: `CHANNELS`=3, `select_nx1`=3, all valid.
  - Required: `in_ready`=3'b000 and `out_valid` falls to 0 after the drain.
- **Backpressure:**
  - Stimulus: FULL with 16'h00AA, `out_ready`=0 for 5 cycles, ch2 valid with 16'h0055.
  - Required: `out_data` stays 16'h00AA, `in_ready`=0. On `out_ready`=1, back-to-back reload with 16'h0055 and no cycle where `out_valid`=0.
- **Round-robin fairness:**
  - Stimulus: `mode`=1, all 4 channels constantly valid with values 16'h0000..16'h0003, `out_ready`=1.
  - Required: `out_channel` sequence 0,1,2,3,0,1 and `out_data` matching.
- **Round-robin skip and mode switch:**
  - Stimulus: `mode`=1, only ch1 and ch3 valid. After granting ch3, switch to `mode`=0 with `select_nx1`=3 for one transfer, then back to `mode`=1.
  - Required: sequence 1,3,3,1. The next round-robin grant after ch3 is ch1.

Source files
------------

// File: rtl/mux_nx1_arb_if.sv
// Handshake and data bundle for the N:1 operand selector.
// The master modport is the environment side and the slave modport is the selector side.
interface mux_nx1_arb_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 4
);
  localparam int SEL_WIDTH = $clog2(CHANNELS);

  logic [CHANNELS*DATA_WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]            in_valid;
  logic [CHANNELS-1:0]            in_ready;
  logic                           mode;
  logic [SEL_WIDTH-1:0]           select_nx1;
  logic [DATA_WIDTH-1:0]          out_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [SEL_WIDTH-1:0]           out_channel;

  modport master (
    output in_data, in_valid, mode, select_nx1, out_ready,
    input  in_ready, out_data, out_valid, out_channel
  );

  modport slave (
    input  in_data, in_valid, mode, select_nx1, out_ready,
    output in_ready, out_data, out_valid, out_channel
  );
endinterface

// File: rtl/mux_nx1_arb.sv
// Registered N:1 operand selector (fixed select or round-robin) with a 1-cycle load latency.
// All in_ready bits drop while the output register is FULL and out_ready is low.
module mux_nx1_arb #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_nx1_arb_if.slave bus
);
  localparam int SEL_WIDTH = $clog2(CHANNELS);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state;
  state_t                state_next;
  logic [SEL_WIDTH-1:0]  rr_ptr;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [SEL_WIDTH-1:0]  chan_reg;
  logic [DATA_WIDTH-1:0] ch_data [CHANNELS];
  logic                  can_load;
  logic                  grant;
  logic                  load;
  logic [SEL_WIDTH-1:0]  grant_idx;

  // rr_ptr < CHANNELS and off <= CHANNELS, so a single subtraction wraps correctly.
  function automatic logic [SEL_WIDTH-1:0] rr_cand(input logic [SEL_WIDTH-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= CHANNELS) sum = sum - CHANNELS;
    return sum[SEL_WIDTH-1:0];
  endfunction

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      ch_data[k] = bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Fixed mode compares against each legal index, so an out-of-range select simply matches nothing.
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    if (!bus.mode) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (bus.select_nx1 == SEL_WIDTH'(k) && bus.in_valid[k]) begin
          grant     = 1'b1;
          grant_idx = SEL_WIDTH'(k);
        end
      end
    end else begin
      for (int off = 1; off <= CHANNELS; off++) begin
        if (!grant && bus.in_valid[rr_cand(rr_ptr, off)]) begin
          grant     = 1'b1;
          grant_idx = rr_cand(rr_ptr, off);
        end
      end
    end
  end

  assign can_load = (state == EMPTY) || bus.out_ready;
  assign load     = rst_n && can_load && grant;

  always_comb begin
    bus.in_ready = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      bus.in_ready[k] = load && (grant_idx == SEL_WIDTH'(k));
    end
  end

  always_comb begin
    state_next = state;
    if (load) begin
      state_next = FULL;
    end else if (bus.out_ready) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // rr_ptr follows every grant, including fixed-mode ones, so switching modes stays fair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
      chan_reg <= '0;
      rr_ptr   <= SEL_WIDTH'(CHANNELS - 1);
    end else if (load) begin
      data_reg <= ch_data[grant_idx];
      chan_reg <= grant_idx;
      rr_ptr   <= grant_idx;
    end
  end

  assign bus.out_data    = data_reg;
  assign bus.out_valid   = (state == FULL);
  assign bus.out_channel = chan_reg;
endmodule

// File: tb/tb_mux_nx1_arb.sv
// Bench for mux_nx1_arb: a 4-channel instance driven from a vector table with a scoreboard queue,
// and a 3-channel instance for the out-of-range select case.
module tb_mux_nx1_arb;
  localparam int DW = 16;
  localparam int NV = 25;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_nx1_arb_if #(.DATA_WIDTH(DW), .CHANNELS(4)) bus4 ();
  mux_nx1_arb_if #(.DATA_WIDTH(DW), .CHANNELS(3)) bus3 ();

  mux_nx1_arb #(.DATA_WIDTH(DW), .CHANNELS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  mux_nx1_arb #(.DATA_WIDTH(DW), .CHANNELS(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic        ordy;
    logic [63:0] data;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [1:0]  exp_chan;
    logic [15:0] exp_data;
  } vec_t;

  typedef struct {
    logic [1:0]  chan;
    logic [15:0] data;
  } exp_t;

  vec_t tbl [NV];
  exp_t sb [$];
  exp_t last;
  exp_t popped;
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [63:0] DA = 64'h0003_0002_0001_0000;
  localparam logic [63:0] DB = 64'h0000_0000_0064_FF49;
  localparam logic [63:0] DC = 64'h0033_0000_0011_0000;
  localparam logic [63:0] DD = 64'h0000_0055_0000_00AA;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r,
                              input logic [63:0] d, input logic [3:0] er, input logic eo,
                              input logic [1:0] ec, input logic [15:0] ed);
    vec_t t;
    t.mode = m; t.sel = s; t.valid = v; t.ordy = r; t.data = d;
    t.exp_rdy = er; t.exp_ov = eo; t.exp_chan = ec; t.exp_data = ed;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Round-robin from reset: channel 0 first, then rotating.
    tbl[0]  = mk(1, 0, 4'b1111, 1, DA, 4'b0001, 1, 0, 16'h0000);
    tbl[1]  = mk(1, 0, 4'b1111, 1, DA, 4'b0010, 1, 1, 16'h0001);
    tbl[2]  = mk(1, 0, 4'b1111, 1, DA, 4'b0100, 1, 2, 16'h0002);
    tbl[3]  = mk(1, 0, 4'b1111, 1, DA, 4'b1000, 1, 3, 16'h0003);
    tbl[4]  = mk(1, 0, 4'b1111, 1, DA, 4'b0001, 1, 0, 16'h0000);
    tbl[5]  = mk(1, 0, 4'b1111, 1, DA, 4'b0010, 1, 1, 16'h0001);
    // Fixed select, then drain to EMPTY.
    tbl[6]  = mk(0, 1, 4'b0010, 1, DB, 4'b0010, 1, 1, 16'h0064);
    tbl[7]  = mk(0, 0, 4'b0011, 1, DB, 4'b0001, 1, 0, 16'hFF49);
    tbl[8]  = mk(0, 0, 4'b0000, 1, DB, 4'b0000, 0, 0, 16'h0000);
    tbl[9]  = mk(0, 0, 4'b0000, 0, DB, 4'b0000, 0, 0, 16'h0000);
    // Round-robin skip with a fixed-mode transfer in between: 1,3,3,1.
    tbl[10] = mk(1, 0, 4'b1010, 1, DC, 4'b0010, 1, 1, 16'h0011);
    tbl[11] = mk(1, 0, 4'b1010, 1, DC, 4'b1000, 1, 3, 16'h0033);
    tbl[12] = mk(0, 3, 4'b1010, 1, DC, 4'b1000, 1, 3, 16'h0033);
    tbl[13] = mk(1, 3, 4'b1010, 1, DC, 4'b0010, 1, 1, 16'h0011);
    // Backpressure: hold 00AA for five cycles while mode/select wiggle, then reload 0055.
    tbl[14] = mk(0, 0, 4'b0101, 1, DD, 4'b0001, 1, 0, 16'h00AA);
    tbl[15] = mk(0, 2, 4'b0100, 0, DD, 4'b0000, 1, 0, 16'h0000);
    tbl[16] = mk(1, 2, 4'b0100, 0, DD, 4'b0000, 1, 0, 16'h0000);
    tbl[17] = mk(0, 3, 4'b0100, 0, DD, 4'b0000, 1, 0, 16'h0000);
    tbl[18] = mk(1, 0, 4'b0100, 0, DD, 4'b0000, 1, 0, 16'h0000);
    tbl[19] = mk(0, 2, 4'b0100, 0, DD, 4'b0000, 1, 0, 16'h0000);
    tbl[20] = mk(0, 2, 4'b0100, 1, DD, 4'b0100, 1, 2, 16'h0055);
    tbl[21] = mk(1, 0, 4'b0000, 0, DD, 4'b0000, 1, 0, 16'h0000);
    tbl[22] = mk(1, 0, 4'b1111, 0, DA, 4'b0000, 1, 0, 16'h0000);
    tbl[23] = mk(1, 0, 4'b1111, 1, DA, 4'b1000, 1, 3, 16'h0003);
    tbl[24] = mk(0, 0, 4'b0000, 1, DA, 4'b0000, 0, 0, 16'h0000);

    rst_n = 1'b0;
    bus4.mode = 1'b1; bus4.select_nx1 = '0; bus4.in_valid = 4'b1111; bus4.out_ready = 1'b1; bus4.in_data = DA;
    bus3.mode = 1'b0; bus3.select_nx1 = '0; bus3.in_valid = '0; bus3.out_ready = 1'b0; bus3.in_data = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready_held", 32'(bus4.in_ready), 32'h0);
    check("rst_out_valid_held", 32'(bus4.out_valid), 32'h0);

    // Load 0049 from ch1 and hold it, then assert reset mid-cycle.
    rst_n = 1'b1;
    bus4.mode = 1'b0; bus4.select_nx1 = 2'd1; bus4.in_valid = 4'b0010; bus4.out_ready = 1'b0;
    bus4.in_data = 64'h0000_0000_0049_0000;
    #1;
    check("pre_rst_in_ready", 32'(bus4.in_ready), 32'h2);
    @(negedge clk);
    check("pre_rst_out_valid", 32'(bus4.out_valid), 32'h1);
    check("pre_rst_out_data", 32'(bus4.out_data), 32'h0049);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus4.out_valid), 32'h0);
    check("rst_out_data", 32'(bus4.out_data), 32'h0);
    check("rst_out_channel", 32'(bus4.out_channel), 32'h0);
    check("rst_in_ready", 32'(bus4.in_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last.chan = '0;
    last.data = '0;

    for (int i = 0; i < NV; i++) begin
      bus4.mode = tbl[i].mode;
      bus4.select_nx1 = tbl[i].sel;
      bus4.in_valid = tbl[i].valid;
      bus4.out_ready = tbl[i].ordy;
      bus4.in_data = tbl[i].data;
      #1;
      check($sformatf("in_ready row %0d", i), 32'(bus4.in_ready), 32'(tbl[i].exp_rdy));
      if (tbl[i].exp_rdy != 4'b0000) begin
        popped.chan = tbl[i].exp_chan;
        popped.data = tbl[i].exp_data;
        sb.push_back(popped);
      end
      @(negedge clk);
      check($sformatf("out_valid row %0d", i), 32'(bus4.out_valid), 32'(tbl[i].exp_ov));
      if (sb.size() > 0) last = sb.pop_front();
      check($sformatf("out_data row %0d", i), 32'(bus4.out_data), 32'(last.data));
      check($sformatf("out_channel row %0d", i), 32'(bus4.out_channel), 32'(last.chan));
    end
    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    // Three-channel instance: select value 3 is out of range.
    bus4.in_valid = '0;
    bus3.mode = 1'b0; bus3.select_nx1 = 2'd2; bus3.in_valid = 3'b111; bus3.out_ready = 1'b1;
    bus3.in_data = 48'h0333_0222_0111;
    #1;
    check("c3_in_ready_sel2", 32'(bus3.in_ready), 32'h4);
    @(negedge clk);
    check("c3_out_valid_load", 32'(bus3.out_valid), 32'h1);
    check("c3_out_data_load", 32'(bus3.out_data), 32'h0333);
    bus3.select_nx1 = 2'd3;
    #1;
    check("c3_in_ready_sel3", 32'(bus3.in_ready), 32'h0);
    @(negedge clk);
    check("c3_out_valid_drained", 32'(bus3.out_valid), 32'h0);
    check("c3_out_data_hold", 32'(bus3.out_data), 32'h0333);
    bus3.mode = 1'b1;
    #1;
    check("c3_in_ready_rr", 32'(bus3.in_ready), 32'h1);
    @(negedge clk);
    check("c3_out_data_rr", 32'(bus3.out_data), 32'h0111);
    check("c3_out_channel_rr", 32'(bus3.out_channel), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
